// File: rtl/playback_sequencer.sv
// playback_sequencer: play state, track/volume control and req/ack sample fetch for the music player
module playback_sequencer #(
  parameter int TRACK_W     = 2,
  parameter int OFFS_W      = 14,
  parameter int DATA_W      = 8,
  parameter int VOL_W       = 4,
  parameter int VOL_DEFAULT = 8,
  parameter int LOOP_ALL    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      play_pause_evt,
  input  logic                      vol_up_evt,
  input  logic                      vol_down_evt,
  input  logic                      fwd_evt,
  input  logic                      bwd_evt,
  input  logic                      sample_tick,
  output logic                      mem_rd_req,
  output logic [TRACK_W+OFFS_W-1:0] mem_addr,
  input  logic                      mem_rd_ack,
  input  logic [DATA_W-1:0]         mem_rd_data,
  output logic [DATA_W-1:0]         sample_out,
  output logic                      sample_valid,
  output logic                      playing,
  output logic [TRACK_W-1:0]        track,
  output logic [VOL_W-1:0]          volume,
  output logic                      overrun
);
  localparam int PW = DATA_W + VOL_W;
  typedef enum logic [1:0] {STOP, PLAY, FETCH, PAUSE} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_FWD, DIR_BWD} dir_t;
  state_t              state_q, state_d;
  dir_t                dir_q, dir_d, dir_n;
  logic [TRACK_W-1:0]  track_q, track_d;
  logic [OFFS_W-1:0]   offs_q, offs_d;
  logic [VOL_W-1:0]    vol_q, vol_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                pp_q, pp_d, pp_n, valid_q, valid_d, overrun_q, overrun_d;
  logic                fwd, bwd, wrap, halt;
  logic [PW-1:0]       prod;
  assign fwd  = fwd_evt & ~bwd_evt;
  assign bwd  = bwd_evt & ~fwd_evt;
  assign pp_n = pp_q ^ play_pause_evt;
  assign prod = PW'(mem_rd_data) * PW'(vol_q);
  // opposite directions inside one fetch cancel; a repeat of the same direction just stays
  assign dir_n = fwd ? (dir_q == DIR_BWD ? DIR_NONE : DIR_FWD) :
                 bwd ? (dir_q == DIR_FWD ? DIR_NONE : DIR_BWD) : dir_q;
  assign wrap  = (dir_n == DIR_NONE) && (&offs_q);
  assign halt  = wrap && (LOOP_ALL == 0) && (&track_q);
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    track_d   = track_q;
    offs_d    = offs_q;
    pp_d      = pp_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    overrun_d = 1'b0;
    vol_d     = (vol_up_evt && !vol_down_evt && vol_q != '1) ? vol_q + 1'b1 :
                (vol_down_evt && !vol_up_evt && vol_q != '0) ? vol_q - 1'b1 : vol_q;
    if (state_q != FETCH) begin
      track_d = fwd ? track_q + 1'b1 : bwd ? track_q - 1'b1 : track_q;
      offs_d  = (fwd || bwd) ? '0 : offs_q;
    end
    case (state_q)
      STOP:  state_d = play_pause_evt ? PLAY : STOP;
      PLAY:  state_d = play_pause_evt ? PAUSE : sample_tick ? FETCH : PLAY;
      PAUSE: state_d = play_pause_evt ? PLAY : PAUSE;
      default: begin
        overrun_d = sample_tick;
        pp_d      = pp_n;
        dir_d     = dir_n;
        if (mem_rd_ack) begin
          sample_d = DATA_W'(prod >> VOL_W);
          valid_d  = 1'b1;
          pp_d     = 1'b0;
          dir_d    = DIR_NONE;
          offs_d   = (dir_n == DIR_NONE) ? offs_q + 1'b1 : '0;
          track_d  = (dir_n == DIR_FWD) ? track_q + 1'b1 :
                     (dir_n == DIR_BWD) ? track_q - 1'b1 :
                     halt ? '0 : wrap ? track_q + 1'b1 : track_q;
          state_d  = halt ? STOP : pp_n ? PAUSE : PLAY;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STOP;
      dir_q     <= DIR_NONE;
      track_q   <= '0;
      offs_q    <= '0;
      vol_q     <= VOL_W'(VOL_DEFAULT);
      pp_q      <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      track_q   <= track_d;
      offs_q    <= offs_d;
      vol_q     <= vol_d;
      pp_q      <= pp_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end
  assign mem_rd_req   = state_q == FETCH;
  assign mem_addr     = {track_q, offs_q};
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign playing      = state_q == PLAY || state_q == FETCH;
  assign track        = track_q;
  assign volume       = vol_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_playback_sequencer.sv
// tb_playback_sequencer: directed checks of playback_sequencer with 8-sample tracks and LOOP_ALL=0
module tb_playback_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       play_pause_evt = 1'b0, vol_up_evt = 1'b0, vol_down_evt = 1'b0;
  logic       fwd_evt = 1'b0, bwd_evt = 1'b0, sample_tick = 1'b0;
  logic       mem_rd_req, mem_rd_ack = 1'b0;
  logic [4:0] mem_addr;
  logic [7:0] mem_rd_data = '0, sample_out;
  logic       sample_valid, playing, overrun;
  logic [1:0] track;
  logic [3:0] volume;
  int         checks = 0, errors = 0;
  playback_sequencer #(.OFFS_W(3), .LOOP_ALL(0)) dut (
    .clk(clk), .rst_n(rst_n), .play_pause_evt(play_pause_evt), .vol_up_evt(vol_up_evt),
    .vol_down_evt(vol_down_evt), .fwd_evt(fwd_evt), .bwd_evt(bwd_evt), .sample_tick(sample_tick),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
    .sample_out(sample_out), .sample_valid(sample_valid), .playing(playing), .track(track),
    .volume(volume), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // inputs set before step are sampled on the next rising edge; outputs checked after it
  task automatic step();
    @(negedge clk);
    {play_pause_evt, vol_up_evt, vol_down_evt, fwd_evt, bwd_evt, sample_tick, mem_rd_ack} = '0;
  endtask
  task automatic fetch(input int lat, input logic [7:0] d, input logic [4:0] a, input logic [7:0] s);
    sample_tick = 1'b1;
    step();
    chk("req_rise", mem_rd_req, 1);
    chk("addr", mem_addr, a);
    for (int i = 1; i < lat; i++) begin
      step();
      chk("addr_hold", mem_addr, a);
    end
    mem_rd_ack = 1'b1;
    mem_rd_data = d;
    step();
    chk("req_fall", mem_rd_req, 0);
    chk("valid", sample_valid, 1);
    chk("sample", sample_out, s);
    step();
    chk("valid_pulse", sample_valid, 0);
  endtask
  initial begin
    step();
    step();
    chk("rst_req", mem_rd_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_sample", sample_out, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_playing", playing, 0);
    chk("rst_track", track, 0);
    chk("rst_volume", volume, 8);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    step();
    sample_tick = 1'b1;
    step();
    chk("stop_tick_req", mem_rd_req, 0);
    play_pause_evt = 1'b1;
    step();
    chk("play", playing, 1);
    for (int i = 0; i < 3; i++) fetch(2, 8'hFF, 5'(i), 8'h7F);
    for (int i = 0; i < 10; i++) begin vol_up_evt = 1'b1; step(); end
    chk("vol_max", volume, 15);
    for (int i = 0; i < 20; i++) begin vol_down_evt = 1'b1; step(); end
    chk("vol_min", volume, 0);
    fetch(1, 8'hFF, 5'd3, 8'h00);
    for (int i = 0; i < 3; i++) begin vol_up_evt = 1'b1; step(); end
    chk("vol_3", volume, 3);
    vol_up_evt = 1'b1;
    vol_down_evt = 1'b1;
    step();
    chk("vol_both", volume, 3);
    bwd_evt = 1'b1;
    step();
    chk("bwd_wrap", track, 3);
    chk("bwd_addr", mem_addr, 5'd24);
    fwd_evt = 1'b1;
    step();
    chk("fwd_wrap", track, 0);
    chk("fwd_addr", mem_addr, 5'd0);
    fwd_evt = 1'b1;
    bwd_evt = 1'b1;
    step();
    chk("trk_both", track, 0);
    chk("trk_both_play", playing, 1);
    sample_tick = 1'b1;
    step();
    chk("pend_req", mem_rd_req, 1);
    fwd_evt = 1'b1;
    step();
    chk("pend_addr1", mem_addr, 5'd0);
    chk("pend_track", track, 0);
    play_pause_evt = 1'b1;
    step();
    chk("pend_addr2", mem_addr, 5'd0);
    chk("pend_playing", playing, 1);
    step();
    step();
    mem_rd_ack = 1'b1;
    mem_rd_data = 8'h80;
    step();
    chk("pend_req_fall", mem_rd_req, 0);
    chk("pend_track_new", track, 1);
    chk("pend_addr_new", mem_addr, 5'd8);
    chk("pend_pause", playing, 0);
    chk("pend_sample", sample_out, 8'h18);
    sample_tick = 1'b1;
    step();
    chk("pause_tick_req", mem_rd_req, 0);
    chk("pause_overrun", overrun, 0);
    play_pause_evt = 1'b1;
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b1;
    step();
    chk("overrun", overrun, 1);
    chk("overrun_req", mem_rd_req, 1);
    step();
    chk("overrun_pulse", overrun, 0);
    mem_rd_ack = 1'b1;
    mem_rd_data = 8'h10;
    step();
    chk("ovr_sample", sample_out, 8'h03);
    chk("ovr_addr", mem_addr, 5'd9);
    step();
    chk("no_second_req", mem_rd_req, 0);
    bwd_evt = 1'b1;
    step();
    bwd_evt = 1'b1;
    step();
    chk("last_track", track, 3);
    for (int i = 0; i < 7; i++) fetch(1, 8'h20, 5'(24 + i), 8'h06);
    fetch(1, 8'h40, 5'd31, 8'h0C);
    chk("end_stop", playing, 0);
    chk("end_track", track, 0);
    chk("end_addr", mem_addr, 0);
    sample_tick = 1'b1;
    step();
    chk("end_stop_tick", mem_rd_req, 0);
    play_pause_evt = 1'b1;
    step();
    sample_tick = 1'b1;
    step();
    chk("rst_pre_req", mem_rd_req, 1);
    rst_n = 1'b0;
    #1;
    chk("async_req", mem_rd_req, 0);
    chk("async_playing", playing, 0);
    chk("async_volume", volume, 8);
    chk("async_track", track, 0);
    chk("async_addr", mem_addr, 0);
    chk("async_sample", sample_out, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
